// File: rtl/bram_sd_sync.sv
// bram_sd_sync: moves the save RAM image to and from the HPS SD block interface.
// Supports multi-sector load/save, autoload after ROM download, and format
// (header words followed by zero-fill).
// Optional build macro BRAM_SD_SYNC_TIMEOUT_EN adds an ack watchdog with a sticky timeout flag.
module bram_sd_sync #(
  parameter int unsigned SECTORS  = 16,
  parameter int unsigned LBA_BASE = 0,
  parameter logic [63:0] HDR      = 64'h8010_8800_4D42_5548,
`ifdef BRAM_SD_SYNC_TIMEOUT_EN
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
`endif
  localparam int unsigned SEC_W = $clog2(SECTORS)
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             bk_ena,
  input  logic             load_req,
  input  logic             save_req,
  input  logic             format_req,
  input  logic             autoload,
  output logic [31:0]      sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  input  logic [7:0]       sd_buff_addr,
  input  logic [15:0]      sd_buff_dout,
  input  logic             sd_buff_wr,
  output logic [15:0]      sd_buff_din,
  output logic [SEC_W+7:0] ram_addr,
  output logic [15:0]      ram_wdata,
  output logic             ram_we,
  input  logic [15:0]      ram_rdata,
  output logic             busy,
  output logic             loading,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned AW = SEC_W + 8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_FMT} state_t;

  state_t            state;
  logic              is_load;
  logic [SEC_W-1:0]  sector;
  logic [AW-1:0]     fa;
  logic              load_q, save_q, fmt_q, ack_q;
  logic              abort;

  logic load_rise, save_rise, fmt_rise, ack_fall;
  assign load_rise = load_req & ~load_q;
  assign save_rise = save_req & ~save_q;
  assign fmt_rise  = format_req & ~fmt_q;
  assign ack_fall  = ack_q & ~sd_ack;

`ifdef BRAM_SD_SYNC_TIMEOUT_EN
  logic [23:0] wd;
  state_t      st_d;
  logic        active;
  assign active = (state == ST_REQ) || (state == ST_XFER);
  assign abort  = active && (wd >= TIMEOUT_CYC - 24'd1);

  // Ack watchdog: restarts on any state change or data strobe.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wd   <= '0;
      st_d <= ST_IDLE;
    end else begin
      st_d <= state;
      if (!active || (state != st_d) || sd_buff_wr) wd <= '0;
      else                                          wd <= wd + 24'd1;
    end
  end
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  // Control FSM with registered SD handshake and status outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      is_load <= 1'b0;
      sector  <= '0;
      fa      <= '0;
      load_q  <= load_req;
      save_q  <= save_req;
      fmt_q   <= format_req;
      ack_q   <= 1'b0;
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      busy    <= 1'b0;
      loading <= 1'b0;
      done    <= 1'b0;
`ifdef BRAM_SD_SYNC_TIMEOUT_EN
      timeout <= 1'b0;
`endif
    end else begin
      load_q <= load_req;
      save_q <= save_req;
      fmt_q  <= format_req;
      ack_q  <= sd_ack;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fmt_rise) begin
            state   <= ST_FMT;
            fa      <= '0;
            sector  <= '0;
            busy    <= 1'b1;
            loading <= 1'b0;
`ifdef BRAM_SD_SYNC_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end else if (bk_ena && (autoload || load_rise || save_rise)) begin
            state   <= ST_REQ;
            is_load <= autoload || load_rise;
            sector  <= '0;
            sd_lba  <= 32'(LBA_BASE);
            sd_rd   <= autoload || load_rise;
            sd_wr   <= !(autoload || load_rise);
            busy    <= 1'b1;
            loading <= autoload || load_rise;
`ifdef BRAM_SD_SYNC_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        ST_REQ: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (ack_fall) begin
            if (sector == '1) begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              loading <= 1'b0;
              done    <= 1'b1;
            end else begin
              sector <= sector + SEC_W'(1);
              sd_lba <= 32'(LBA_BASE) + 32'(sector) + 32'd1;
              sd_rd  <= is_load;
              sd_wr  <= !is_load;
              state  <= ST_REQ;
            end
          end
        end
        ST_FMT: begin
          fa <= fa + AW'(1);
          if (fa == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (abort) begin
        state   <= ST_IDLE;
        sd_rd   <= 1'b0;
        sd_wr   <= 1'b0;
        busy    <= 1'b0;
        loading <= 1'b0;
        done    <= 1'b0;
`ifdef BRAM_SD_SYNC_TIMEOUT_EN
        timeout <= 1'b1;
`endif
      end
    end
  end

  // RAM port B and HPS data path: direct pass-through during XFER, header/zero writes during FMT.
  always_comb begin
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_we      = 1'b0;
    sd_buff_din = '0;
    case (state)
      ST_XFER: begin
        ram_addr = {sector, sd_buff_addr};
        if (is_load) begin
          ram_we    = sd_buff_wr & sd_ack;
          ram_wdata = sd_buff_dout;
        end else begin
          sd_buff_din = ram_rdata;
        end
      end
      ST_FMT: begin
        ram_addr = fa;
        ram_we   = 1'b1;
        if (fa[AW-1:2] == '0) ram_wdata = HDR[{fa[1:0], 4'b0000} +: 16];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bram_sd_sync.sv
// Self-checking bench for bram_sd_sync: HPS and RAM models plus an expected-image reference.
`define CHK(TAG, OBS, EXP) begin total++; assert ((OBS) === (EXP)) else begin bad++; $error("FAIL %s obs=%0h exp=%0h", TAG, OBS, EXP); end end

module tb_bram_sd_sync;
  localparam int unsigned SECTORS = 16;
  localparam int unsigned LBA     = 32'h100;
  localparam int unsigned NW      = SECTORS * 256;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        bk_ena = 1'b0, load_req = 1'b0, save_req = 1'b0, format_req = 1'b0, autoload = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_buff_addr = '0;
  logic [15:0] sd_buff_dout = '0;
  logic        sd_buff_wr = 1'b0;
  logic [15:0] sd_buff_din;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic        busy, loading, done, timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  bram_sd_sync #(
    .SECTORS(SECTORS),
    .LBA_BASE(LBA)
`ifdef BRAM_SD_SYNC_TIMEOUT_EN
    , .TIMEOUT_CYC(24'd1000)
`endif
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bk_ena(bk_ena),
    .load_req(load_req), .save_req(save_req), .format_req(format_req), .autoload(autoload),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy), .loading(loading), .done(done), .timeout(timeout)
  );

  // Save RAM port B with one-cycle read latency.
  logic [15:0] mem [0:NW-1];
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Activity monitor: event counters sampled on the falling edge.
  int n_done = 0, n_rd = 0, n_wr = 0, n_sd = 0, n_busy = 0;
  logic rd_p = 1'b0, wr_p = 1'b0;
  always @(negedge clk_sys) begin
    if (done) n_done++;
    if (sd_rd && !rd_p) n_rd++;
    if (sd_wr && !wr_p) n_wr++;
    if (sd_rd || sd_wr) n_sd++;
    if (busy) n_busy++;
    rd_p = sd_rd;
    wr_p = sd_wr;
  end

  // Reference image of what the save RAM must hold.
  logic [15:0] exp_mem [0:NW-1];
  logic [15:0] cap37;

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk_sys); #1; end
  endtask

  task automatic wait_req(input bit want_rd, output bit ok);
    int t = 0;
    while (!(want_rd ? sd_rd : sd_wr) && t < 50) begin cyc(1); t++; end
    ok = want_rd ? sd_rd : sd_wr;
  endtask

  task automatic compare_image(input string tag);
    int mism = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== exp_mem[i]) mism++;
    `CHK(tag, mism, 0)
  endtask

  task automatic serve_load(input int s, input bit rnd);
    bit ok;
    logic [15:0] d;
    wait_req(1'b1, ok);
    `CHK("ld_req", ok, 1'b1)
    if (!ok) return;
    `CHK("ld_lba", sd_lba, 32'(LBA + s))
    `CHK("ld_loading", loading, 1'b1)
    cyc($urandom_range(0, 2));
    sd_ack = 1'b1;
    cyc(1);
    `CHK("ld_rd_drop", sd_rd, 1'b0)
    for (int w = 0; w < 256; w++) begin
      d = rnd ? 16'($urandom) : 16'((s << 8) | w);
      exp_mem[s * 256 + w] = d;
      sd_buff_addr = 8'(w);
      sd_buff_dout = d;
      sd_buff_wr   = 1'b1;
      cyc(1);
    end
    sd_buff_wr = 1'b0;
    cyc(1);
    sd_ack = 1'b0;
    cyc(1);
    if (s == SECTORS - 1) begin
      `CHK("ld_done", done, 1'b1)
      `CHK("ld_busy_end", busy, 1'b0)
    end else begin
      `CHK("ld_gap", sd_rd, 1'b1)
    end
  endtask

  task automatic serve_save(input int s);
    bit ok;
    int mism = 0;
    logic [15:0] got;
    wait_req(1'b0, ok);
    `CHK("sv_req", ok, 1'b1)
    if (!ok) return;
    `CHK("sv_lba", sd_lba, 32'(LBA + s))
    `CHK("sv_no_rd", sd_rd, 1'b0)
    cyc($urandom_range(0, 2));
    sd_ack = 1'b1;
    cyc(1);
    `CHK("sv_wr_drop", sd_wr, 1'b0)
    sd_buff_addr = 8'd0;
    cyc(1);
    for (int w = 0; w < 256; w++) begin
      got = sd_buff_din;
      if (got !== exp_mem[s * 256 + w]) mism++;
      if (s == 3 && w == 127) cap37 = got;
      sd_buff_addr = 8'(w + 1);
      cyc(1);
    end
    `CHK("sv_data", mism, 0)
    sd_ack = 1'b0;
    cyc(1);
    if (s == SECTORS - 1) begin
      `CHK("sv_done", done, 1'b1)
    end else begin
      `CHK("sv_gap", sd_wr, 1'b1)
    end
  endtask

  task automatic wait_idle(output int t);
    t = 0;
    while (busy && t < 6000) begin cyc(1); t++; end
  endtask

  initial begin
    int d0, r0, w0, s0, b0, t;

    // Reset state
    cyc(3);
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_sd_rd", sd_rd, 1'b0)
    `CHK("rst_sd_wr", sd_wr, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_lba", sd_lba, 32'd0)
    `CHK("rst_timeout", timeout, 1'b0)
    `CHK("rst_ram_we", ram_we, 1'b0)
    reset_n = 1'b1;
    cyc(2);

    // Full load with the {sector, addr} pattern
    bk_ena = 1'b1;
    d0 = n_done; r0 = n_rd; w0 = n_wr;
    load_req = 1'b1;
    cyc(1);
    `CHK("ld_start_busy", busy, 1'b1)
    for (int s = 0; s < SECTORS; s++) serve_load(s, 1'b0);
    `CHK("ld_ndone", n_done - d0, 1)
    `CHK("ld_nrd", n_rd - r0, 16)
    `CHK("ld_nwr", n_wr - w0, 0)
    `CHK("ld_word5a3", mem[12'h5A3], 16'h05A3)
    compare_image("ld_image");

    // Save back the loaded image
    d0 = n_done; r0 = n_rd; w0 = n_wr;
    save_req = 1'b1;
    cyc(1);
    `CHK("sv_start_busy", busy, 1'b1)
    `CHK("sv_not_loading", loading, 1'b0)
    for (int s = 0; s < SECTORS; s++) serve_save(s);
    `CHK("sv_word37f", cap37, 16'h037F)
    `CHK("sv_nrd", n_rd - r0, 0)
    `CHK("sv_nwr", n_wr - w0, 16)
    `CHK("sv_ndone", n_done - d0, 1)

    // Autoload pulse with random data
    load_req = 1'b0; save_req = 1'b0;
    cyc(2);
    autoload = 1'b1;
    cyc(1);
    autoload = 1'b0;
    `CHK("al_loading", loading, 1'b1)
    for (int s = 0; s < SECTORS; s++) serve_load(s, 1'b1);
    compare_image("al_image");

    // Format
    d0 = n_done; s0 = n_sd; b0 = n_busy;
    format_req = 1'b1;
    cyc(1);
    `CHK("fmt_busy", busy, 1'b1)
    wait_idle(t);
    `CHK("fmt_finished", busy, 1'b0)
    `CHK("fmt_busy_cycles", n_busy - b0, 4096)
    `CHK("fmt_no_sd", n_sd - s0, 0)
    `CHK("fmt_ndone", n_done - d0, 1)
    for (int i = 0; i < NW; i++) exp_mem[i] = 16'h0000;
    exp_mem[0] = 16'h5548; exp_mem[1] = 16'h4D42; exp_mem[2] = 16'h8800; exp_mem[3] = 16'h8010;
    `CHK("fmt_hdr0", mem[0], 16'h5548)
    `CHK("fmt_hdr3", mem[3], 16'h8010)
    compare_image("fmt_image");

    // Simultaneous format and load edges; save edge during format is dropped
    format_req = 1'b0;
    cyc(2);
    d0 = n_done; s0 = n_sd; b0 = n_busy;
    format_req = 1'b1; load_req = 1'b1;
    cyc(1);
    `CHK("sim_busy", busy, 1'b1)
    `CHK("sim_not_loading", loading, 1'b0)
    cyc(100);
    save_req = 1'b1;
    wait_idle(t);
    cyc(20);
    `CHK("sim_busy_cycles", n_busy - b0, 4096)
    `CHK("sim_no_sd", n_sd - s0, 0)
    `CHK("sim_ndone", n_done - d0, 1)
    `CHK("sim_idle", busy, 1'b0)
    compare_image("sim_image");

    // bk_ena=0 blocks load
    load_req = 1'b0;
    cyc(2);
    bk_ena = 1'b0;
    d0 = n_done; r0 = n_rd;
    load_req = 1'b1;
    cyc(10);
    `CHK("bk0_busy", busy, 1'b0)
    `CHK("bk0_ndone", n_done - d0, 0)
    `CHK("bk0_nrd", n_rd - r0, 0)

    // Reset during sector 5 of a save
    bk_ena = 1'b1; load_req = 1'b0; save_req = 1'b0;
    cyc(2);
    save_req = 1'b1;
    cyc(1);
    for (int s = 0; s < 5; s++) serve_save(s);
    begin
      bit ok;
      wait_req(1'b0, ok);
      `CHK("rs_req5", ok, 1'b1)
      `CHK("rs_lba5", sd_lba, 32'h105)
    end
    d0 = n_done;
    reset_n = 1'b0;
    #1;
    `CHK("rs_wr_drop", sd_wr, 1'b0)
    `CHK("rs_busy_drop", busy, 1'b0)
    `CHK("rs_loading", loading, 1'b0)
    cyc(3);
    w0 = n_wr;
    reset_n = 1'b1;
    cyc(10);
    `CHK("rs_no_done", n_done - d0, 0)
    `CHK("rs_no_spurious", busy, 1'b0)
    `CHK("rs_no_wr", n_wr - w0, 0)

`ifdef BRAM_SD_SYNC_TIMEOUT_EN
    // Watchdog: HPS never acks
    load_req = 1'b0;
    cyc(2);
    load_req = 1'b1;
    cyc(1);
    `CHK("to_busy", busy, 1'b1)
    t = 0;
    while (busy && t < 2000) begin cyc(1); t++; end
    `CHK("to_flag", timeout, 1'b1)
    `CHK("to_idle", busy, 1'b0)
    `CHK("to_rd_drop", sd_rd, 1'b0)
    `CHK("to_window", (t >= 990 && t <= 1010), 1'b1)
    load_req = 1'b0;
    cyc(2);
    load_req = 1'b1;
    cyc(1);
    `CHK("to_clear", timeout, 1'b0)
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
